// File: rtl/ir_pkt_pkg.sv
// Shared types, default per-car length tables and segment-length lookup for the IR packet generator.
// The PARITY state exists only when IR_PKT_PARITY_EN is defined.
package ir_pkt_pkg;

    localparam int unsigned NUM_CAR = 4;
    localparam int unsigned LEN_W   = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_GAP,
        ST_CARSEL,
        ST_CMD
`ifdef IR_PKT_PARITY_EN
        , ST_PARITY
`endif
    } state_t;

    typedef logic [1:0] car_t;

    typedef logic [NUM_CAR-1:0][LEN_W-1:0] len_tbl_t;

    localparam len_tbl_t DEF_START_LEN = {32'd88, 32'd88, 32'd191, 32'd192};
    localparam len_tbl_t DEF_CAR_LEN   = {32'd44, 32'd22, 32'd47, 32'd24};

    typedef struct packed {
        len_tbl_t         start_len;
        len_tbl_t         car_len;
        logic [LEN_W-1:0] gap_len;
        logic [LEN_W-1:0] assert_len;
        logic [LEN_W-1:0] deassert_len;
    } len_cfg_t;

    // Length of the current segment; callers narrow the result to their counter width.
    function automatic logic [LEN_W-1:0] seg_len(state_t st, car_t car, logic cmd_bit, len_cfg_t cfg);
        case (st)
            ST_START:  seg_len = cfg.start_len[car];
            ST_CARSEL: seg_len = cfg.car_len[car];
            ST_GAP:    seg_len = cfg.gap_len;
            default:   seg_len = cmd_bit ? cfg.assert_len : cfg.deassert_len;
        endcase
    endfunction

endpackage

// File: rtl/ir_packet_gen_multi_if.sv
// Request/status handshake between the scheduler/direction FSM and the IR packet generator.
interface ir_packet_gen_multi_if #(
    parameter int unsigned NUM_CMD = 4
);
    import ir_pkt_pkg::*;

    logic               PKT_START;
    car_t               CAR_SEL;
    logic [NUM_CMD-1:0] CMD;
    logic               BUSY;
    logic               DONE;

    modport master (output PKT_START, CAR_SEL, CMD, input BUSY, DONE);
    modport slave  (input PKT_START, CAR_SEL, CMD, output BUSY, DONE);

endinterface

// File: rtl/ir_burst_counter.sv
// Carrier-period counter for one segment; term_c flags the strobe that completes the segment.
module ir_burst_counter #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             strobe,
    input  logic [CNT_W-1:0] len,
    output logic             term_c
);

    logic [CNT_W-1:0] count;

    assign term_c = en && strobe && (count == len - CNT_W'(1));

    // Held at zero while disabled so every segment starts from a clean count.
    always_ff @(posedge clk) begin
        if (!rst_n || !en) begin
            count <= '0;
        end else if (term_c) begin
            count <= '0;
        end else if (strobe) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/ir_packet_gen_multi.sv
// IR packet generator: start burst, car-select burst and NUM_CMD command bursts, each followed by a gap.
// Defining IR_PKT_PARITY_EN appends a parity burst and gap after the last command gap.
module ir_packet_gen_multi
    import ir_pkt_pkg::*;
#(
    parameter int unsigned NUM_CMD      = 4,
    parameter int unsigned CNT_W        = 8,
    parameter int unsigned START_LEN_0  = DEF_START_LEN[0],
    parameter int unsigned START_LEN_1  = DEF_START_LEN[1],
    parameter int unsigned START_LEN_2  = DEF_START_LEN[2],
    parameter int unsigned START_LEN_3  = DEF_START_LEN[3],
    parameter int unsigned CAR_LEN_0    = DEF_CAR_LEN[0],
    parameter int unsigned CAR_LEN_1    = DEF_CAR_LEN[1],
    parameter int unsigned CAR_LEN_2    = DEF_CAR_LEN[2],
    parameter int unsigned CAR_LEN_3    = DEF_CAR_LEN[3],
    parameter int unsigned GAP_LEN      = 24,
    parameter int unsigned ASSERT_LEN   = 48,
    parameter int unsigned DEASSERT_LEN = 24
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  PULSE,
    input  logic                  PULSE_STROBE,
    ir_packet_gen_multi_if.slave  bus,
    output logic                  IR_LED
);

    localparam int unsigned IDX_W = (NUM_CMD > 1) ? $clog2(NUM_CMD) : 1;

    localparam len_cfg_t CFG = {
        32'(START_LEN_3), 32'(START_LEN_2), 32'(START_LEN_1), 32'(START_LEN_0),
        32'(CAR_LEN_3),   32'(CAR_LEN_2),   32'(CAR_LEN_1),   32'(CAR_LEN_0),
        32'(GAP_LEN),     32'(ASSERT_LEN),  32'(DEASSERT_LEN)
    };

    state_t             state;
    state_t             next_seg;
    logic [IDX_W-1:0]   cmd_idx;
    logic [NUM_CMD-1:0] cmd_q;
    car_t               car_q;
    logic               busy_q;
    logic               done_q;
    logic               burst_on;

    logic               seg_bit_c;
    logic [CNT_W-1:0]   seg_len_c;
    logic               seg_end_c;

    always_comb begin
        seg_bit_c = cmd_q[cmd_idx];
`ifdef IR_PKT_PARITY_EN
        if (state == ST_PARITY) seg_bit_c = ^cmd_q;
`endif
        seg_len_c = CNT_W'(seg_len(state, car_q, seg_bit_c, CFG));
    end

    ir_burst_counter #(.CNT_W(CNT_W)) u_cnt (
        .clk    (CLK),
        .rst_n  (RST),
        .en     (state != ST_IDLE),
        .strobe (PULSE_STROBE),
        .len    (seg_len_c),
        .term_c (seg_end_c)
    );

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state    <= ST_IDLE;
            next_seg <= ST_IDLE;
            cmd_idx  <= '0;
            cmd_q    <= '0;
            car_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            burst_on <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (state == ST_IDLE) begin
                if (bus.PKT_START) begin
                    state    <= ST_START;
                    cmd_q    <= bus.CMD;
                    car_q    <= bus.CAR_SEL;
                    cmd_idx  <= '0;
                    busy_q   <= 1'b1;
                    burst_on <= 1'b1;
                end
            end else if (seg_end_c) begin
                // Every burst is followed by a gap; next_seg records where the gap leads.
                state    <= ST_GAP;
                burst_on <= 1'b0;
                case (state)
                    ST_START:  next_seg <= ST_CARSEL;
                    ST_CARSEL: next_seg <= ST_CMD;
                    ST_CMD: begin
                        if (cmd_idx == IDX_W'(NUM_CMD - 1)) begin
`ifdef IR_PKT_PARITY_EN
                            next_seg <= ST_PARITY;
`else
                            next_seg <= ST_IDLE;
`endif
                        end else begin
                            next_seg <= ST_CMD;
                            cmd_idx  <= cmd_idx + IDX_W'(1);
                        end
                    end
`ifdef IR_PKT_PARITY_EN
                    ST_PARITY: next_seg <= ST_IDLE;
`endif
                    ST_GAP: begin
                        state    <= next_seg;
                        burst_on <= (next_seg != ST_IDLE);
                        if (next_seg == ST_IDLE) begin
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                        end
                    end
                    default: next_seg <= ST_IDLE;
                endcase
            end
        end
    end

    assign bus.BUSY = busy_q;
    assign bus.DONE = done_q;
    assign IR_LED   = PULSE & burst_on;

endmodule

// File: tb/tb_ir_packet_gen_multi.sv
// Scoreboard bench for ir_packet_gen_multi: expected segment runs are queued at each request and
// compared against the on/off strobe runs observed on IR_LED when DONE fires.
module tb_ir_packet_gen_multi;

    localparam int NUM_CMD  = 4;
    localparam int GAP      = 2;
    localparam int A_LEN    = 6;
    localparam int D_LEN    = 3;
    localparam int MAX_WAIT = 4000;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    logic PULSE = 1'b0;
    logic PULSE_STROBE = 1'b0;
    logic IR_LED;

    ir_packet_gen_multi_if #(.NUM_CMD(NUM_CMD)) bus ();

    ir_packet_gen_multi #(
        .NUM_CMD(NUM_CMD), .CNT_W(8), .START_LEN_0(8), .CAR_LEN_0(4),
        .GAP_LEN(GAP), .ASSERT_LEN(A_LEN), .DEASSERT_LEN(D_LEN)
    ) dut (
        .CLK(CLK), .RST(RST), .PULSE(PULSE), .PULSE_STROBE(PULSE_STROBE),
        .bus(bus), .IR_LED(IR_LED)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int unsigned n;
        int unsigned seg[16];
    } exp_pkt_t;

    exp_pkt_t exp_q[$];
    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: list of segment lengths, alternating burst/gap, starting with a burst.
    function automatic exp_pkt_t model(input int car, input logic [3:0] cmd);
        exp_pkt_t e;
        int unsigned st_len[4] = '{8, 191, 88, 88};
        int unsigned cr_len[4] = '{4, 47, 22, 44};
        foreach (e.seg[k]) e.seg[k] = 0;
        e.seg[0] = st_len[car];
        e.seg[1] = GAP;
        e.seg[2] = cr_len[car];
        e.seg[3] = GAP;
        e.n = 4;
        for (int i = 0; i < NUM_CMD; i++) begin
            e.seg[e.n]     = cmd[i] ? A_LEN : D_LEN;
            e.seg[e.n + 1] = GAP;
            e.n += 2;
        end
`ifdef IR_PKT_PARITY_EN
        e.seg[e.n]     = (^cmd) ? A_LEN : D_LEN;
        e.seg[e.n + 1] = GAP;
        e.n += 2;
`endif
        return e;
    endfunction

    // Carrier: period 4 CLK, high for 2, strobe on the first high cycle.
    initial begin
        int ph = 0;
        forever begin
            @(posedge CLK);
            #1;
            PULSE_STROBE = (ph == 0);
            PULSE        = (ph < 2);
            ph           = (ph + 1) % 4;
        end
    end

    int  run_len[$];
    bit  run_lvl[$];
    bit  busy_seen = 0;
    bit  done_prev = 0;

    task automatic check_packet();
        exp_pkt_t e;
        if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_packet: got %0d segments expected none", run_len.size());
        end else begin
            e = exp_q.pop_front();
            chk("seg_count", run_len.size(), int'(e.n));
            for (int k = 0; k < int'(e.n) && k < run_len.size(); k++) begin
                chk($sformatf("seg%0d_len", k), run_len[k], int'(e.seg[k]));
                chk($sformatf("seg%0d_level", k), int'(run_lvl[k]), int'(k % 2 == 0));
            end
        end
        run_len.delete();
        run_lvl.delete();
    endtask

    // Monitor: collect strobe-level runs of IR_LED while BUSY, judge at DONE.
    always @(negedge CLK) begin
        if (!RST) begin
            if (busy_seen && exp_q.size() > 0) exp_q.delete(0);
            busy_seen = 0;
            done_prev = 0;
            run_len.delete();
            run_lvl.delete();
        end else begin
            if (bus.BUSY) busy_seen = 1;
            if (bus.BUSY && PULSE_STROBE) begin
                if (run_lvl.size() == 0 || run_lvl[run_lvl.size() - 1] != IR_LED) begin
                    run_lvl.push_back(IR_LED);
                    run_len.push_back(1);
                end else begin
                    run_len[run_len.size() - 1] += 1;
                end
            end
            if (bus.DONE) begin
                chk("done_width", int'(done_prev), 0);
                chk("done_busy", int'(bus.BUSY), 0);
                check_packet();
                busy_seen = 0;
            end
            done_prev = bus.DONE;
        end
    end

    task automatic wait_idle();
        int t = 0;
        @(negedge CLK);
        while (bus.BUSY && t < MAX_WAIT) begin
            @(negedge CLK);
            t++;
        end
        if (bus.BUSY) chk("idle_timeout", 1, 0);
    endtask

    task automatic wait_done();
        int t = 0;
        @(negedge CLK);
        while (!bus.DONE && t < MAX_WAIT) begin
            @(negedge CLK);
            t++;
        end
        if (!bus.DONE) chk("done_timeout", 0, 1);
    endtask

    task automatic send(input int car, input logic [3:0] cmd);
        wait_idle();
        @(posedge CLK);
        #1;
        bus.PKT_START = 1'b1;
        bus.CAR_SEL   = 2'(car);
        bus.CMD       = cmd;
        exp_q.push_back(model(car, cmd));
        @(posedge CLK);
        #1;
        bus.PKT_START = 1'b0;
        bus.CMD       = 4'($urandom);
        bus.CAR_SEL   = 2'($urandom);
        @(negedge CLK);
        chk("accept_busy", int'(bus.BUSY), 1);
    endtask

    // Called at the negedge of the DONE cycle: request lands in that same cycle.
    task automatic b2b(input int car, input logic [3:0] cmd);
        bus.PKT_START = 1'b1;
        bus.CAR_SEL   = 2'(car);
        bus.CMD       = cmd;
        exp_q.push_back(model(car, cmd));
        @(posedge CLK);
        #1;
        bus.PKT_START = 1'b0;
        @(negedge CLK);
        chk("b2b_busy", int'(bus.BUSY), 1);
    endtask

    task automatic scramble(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
            bus.CMD     = 4'($urandom);
            bus.CAR_SEL = 2'($urandom);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int car;
        logic [3:0] cmd;
        bus.PKT_START = 1'b0;
        bus.CAR_SEL   = '0;
        bus.CMD       = '0;
        RST           = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        RST = 1'b1;
        @(negedge CLK);
        chk("rst_busy", int'(bus.BUSY), 0);
        chk("rst_done", int'(bus.DONE), 0);
        chk("rst_led", int'(IR_LED), 0);

        // Latched command survives input changes mid-packet.
        send(0, 4'b0101);
        scramble(60);
        wait_done();

        // Starts during BUSY are dropped; start in DONE cycle chains immediately.
        send(0, 4'b1010);
        repeat (5) begin
            @(posedge CLK);
            #1;
            bus.PKT_START = 1'b1;
            bus.CMD       = 4'($urandom);
        end
        @(posedge CLK);
        #1;
        bus.PKT_START = 1'b0;
        wait_done();
        b2b(2, 4'b0110);
        wait_done();

        // Reset during CMD[1] aborts; the following packet is complete.
        send(0, 4'b0011);
        repeat (104) @(posedge CLK);
        #1;
        RST = 1'b0;
        @(posedge CLK);
        #1;
        RST = 1'b1;
        @(negedge CLK);
        chk("abort_busy", int'(bus.BUSY), 0);
        chk("abort_led", int'(IR_LED), 0);
        chk("abort_done", int'(bus.DONE), 0);
        send(0, 4'b0011);
        wait_done();

        // Default-table car profile.
        send(1, 4'b1001);
        wait_done();

        send(0, 4'b0111);
        wait_done();
        send(0, 4'b0011);
        wait_done();

        repeat (12) begin
            car = $urandom_range(0, 3);
            cmd = 4'($urandom);
            send(car, cmd);
            if ($urandom_range(0, 1) == 1) scramble(20);
            wait_done();
            if ($urandom_range(0, 2) == 0) begin
                b2b($urandom_range(0, 3), 4'($urandom));
                wait_done();
            end
        end

        wait_idle();
        repeat (8) @(posedge CLK);
        chk("queue_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
